// File: rtl/traffic_phase_scheduler.sv
// Demand-actuated NS/EW/pedestrian phase scheduler: green -> yellow -> all-red, min/max green, round-robin.
// Lamps are a Moore decode of the phase register (no extra latency); requests are levels, ped is latched.
module traffic_phase_scheduler #(
    parameter int MIN_GREEN      = 20,
    parameter int MAX_GREEN      = 50,
    parameter int YELLOW_CYCLES  = 10,
    parameter int ALL_RED_CYCLES = 4,
    parameter int WALK_CYCLES    = 30,
    parameter int TIMER_W        = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ns_req,
    input  logic       ew_req,
    input  logic       ped_req,
    output logic       ns_g,
    output logic       ns_y,
    output logic       ns_r,
    output logic       ew_g,
    output logic       ew_y,
    output logic       ew_r,
    output logic       walk,
    output logic       ped_ack,
    output logic [2:0] phase
);

    localparam logic [2:0] NS_GREEN = 3'd0;
    localparam logic [2:0] NS_YEL   = 3'd1;
    localparam logic [2:0] EW_GREEN = 3'd2;
    localparam logic [2:0] EW_YEL   = 3'd3;
    localparam logic [2:0] ALL_RED  = 3'd4;
    localparam logic [2:0] PED_WALK = 3'd5;

    localparam logic [TIMER_W-1:0] MIN_LAST  = TIMER_W'(MIN_GREEN - 1);
    localparam logic [TIMER_W-1:0] MAX_LAST  = TIMER_W'(MAX_GREEN - 1);
    localparam logic [TIMER_W-1:0] YEL_LAST  = TIMER_W'(YELLOW_CYCLES - 1);
    localparam logic [TIMER_W-1:0] AR_LAST   = TIMER_W'(ALL_RED_CYCLES - 1);
    localparam logic [TIMER_W-1:0] WALK_LAST = TIMER_W'(WALK_CYCLES - 1);

    logic [2:0]         phase_q, phase_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               ped_pending_q, ped_pending_d;
    logic               last_dir_ew_q, last_dir_ew_d;
    logic               last_was_ped_q, last_was_ped_d;

    logic in_green, min_ok, at_max, phase_chg;

    assign in_green  = (phase_q == NS_GREEN) || (phase_q == EW_GREEN);
    assign min_ok    = (timer_q >= MIN_LAST);
    assign at_max    = (timer_q == MAX_LAST);
    assign phase_chg = (phase_d != phase_q);

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            phase_q        <= ALL_RED;
            timer_q        <= '0;
            ped_pending_q  <= 1'b0;
            last_dir_ew_q  <= 1'b1;
            last_was_ped_q <= 1'b0;
        end else begin
            phase_q        <= phase_d;
            timer_q        <= timer_d;
            ped_pending_q  <= ped_pending_d;
            last_dir_ew_q  <= last_dir_ew_d;
            last_was_ped_q <= last_was_ped_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        case (phase_q)
            NS_GREEN: if (min_ok && (ew_req || ped_pending_q) && (!ns_req || at_max)) phase_d = NS_YEL;
            EW_GREEN: if (min_ok && (ns_req || ped_pending_q) && (!ew_req || at_max)) phase_d = EW_YEL;
            NS_YEL:   if (timer_q == YEL_LAST) phase_d = ALL_RED;
            EW_YEL:   if (timer_q == YEL_LAST) phase_d = ALL_RED;
            PED_WALK: if (timer_q == WALK_LAST) phase_d = ALL_RED;
            ALL_RED: begin
                if (timer_q == AR_LAST) begin
                    if (ped_pending_q && !last_was_ped_q) phase_d = PED_WALK;
                    else if (last_dir_ew_q)               phase_d = NS_GREEN;
                    else                                  phase_d = EW_GREEN;
                end
            end
            default: phase_d = ALL_RED;
        endcase
    end

    // Timer and round-robin bookkeeping follow the chosen next phase.
    always_comb begin
        timer_d        = timer_q + TIMER_W'(1);
        ped_pending_d  = ped_pending_q | (ped_req && (phase_q != PED_WALK));
        last_dir_ew_d  = last_dir_ew_q;
        last_was_ped_d = last_was_ped_q;
        if (phase_chg) begin
            timer_d = '0;
            case (phase_d)
                NS_GREEN: begin last_dir_ew_d = 1'b0; last_was_ped_d = 1'b0; end
                EW_GREEN: begin last_dir_ew_d = 1'b1; last_was_ped_d = 1'b0; end
                PED_WALK: begin ped_pending_d = 1'b0; last_was_ped_d = 1'b1; end
                default: ;
            endcase
        end else if (in_green && at_max) begin
            timer_d = timer_q;
        end
    end

    always_comb begin
        ns_g    = 1'b0;
        ns_y    = 1'b0;
        ns_r    = 1'b1;
        ew_g    = 1'b0;
        ew_y    = 1'b0;
        ew_r    = 1'b1;
        walk    = 1'b0;
        ped_ack = 1'b0;
        phase   = phase_q;
        case (phase_q)
            NS_GREEN: begin ns_g = 1'b1; ns_r = 1'b0; end
            NS_YEL:   begin ns_y = 1'b1; ns_r = 1'b0; end
            EW_GREEN: begin ew_g = 1'b1; ew_r = 1'b0; end
            EW_YEL:   begin ew_y = 1'b1; ew_r = 1'b0; end
            PED_WALK: begin walk = 1'b1; ped_ack = (timer_q == '0); end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler: directed scenarios plus random demand against a rule-level model.
// Inputs change on the falling edge; outputs are compared on the falling edge.
module tb_traffic_phase_scheduler;

    localparam int MIN  = 4;
    localparam int MAX  = 8;
    localparam int YEL  = 2;
    localparam int AR   = 2;
    localparam int WALK = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       ns_req = 1'b0, ew_req = 1'b0, ped_req = 1'b0;
    logic       ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk, ped_ack;
    logic [2:0] phase;

    traffic_phase_scheduler #(
        .MIN_GREEN(MIN), .MAX_GREEN(MAX), .YELLOW_CYCLES(YEL),
        .ALL_RED_CYCLES(AR), .WALK_CYCLES(WALK), .TIMER_W(8)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ns_req(ns_req), .ew_req(ew_req), .ped_req(ped_req),
        .ns_g(ns_g), .ns_y(ns_y), .ns_r(ns_r), .ew_g(ew_g), .ew_y(ew_y), .ew_r(ew_r),
        .walk(walk), .ped_ack(ped_ack), .phase(phase)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int ph_cnt[8];
    int ack_seen;

    // Model state: phase code, cycles spent in it, latched ped, last served direction, last was ped.
    int m_phase, m_el;
    bit m_pend, m_lastew, m_lastped;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk}
    function automatic logic [6:0] lamp_of(input int p);
        case (p)
            0:       return 7'b100_001_0;
            1:       return 7'b010_001_0;
            2:       return 7'b001_100_0;
            3:       return 7'b001_010_0;
            5:       return 7'b001_001_1;
            default: return 7'b001_001_0;
        endcase
    endfunction

    task automatic model_reset();
        m_phase = 4; m_el = 0; m_pend = 0; m_lastew = 1; m_lastped = 0;
    endtask

    task automatic model_step(input bit ns, input bit ew, input bit ped);
        int np;
        np = m_phase;
        case (m_phase)
            0: if (m_el >= MIN-1 && (ew || m_pend) && (!ns || m_el >= MAX-1)) np = 1;
            2: if (m_el >= MIN-1 && (ns || m_pend) && (!ew || m_el >= MAX-1)) np = 3;
            1, 3: if (m_el == YEL-1) np = 4;
            4: if (m_el == AR-1) np = (m_pend && !m_lastped) ? 5 : (m_lastew ? 0 : 2);
            5: if (m_el == WALK-1) np = 4;
            default: np = 4;
        endcase
        if (ped && m_phase != 5) m_pend = 1;
        if (np != m_phase) begin
            m_el = 0;
            if (np == 5) begin m_pend = 0; m_lastped = 1; end
            if (np == 0) begin m_lastew = 0; m_lastped = 0; end
            if (np == 2) begin m_lastew = 1; m_lastped = 0; end
        end else begin
            m_el++;
        end
        m_phase = np;
    endtask

    task automatic compare_outputs();
        chk("phase", 32'(phase), 32'(m_phase));
        chk("lamps", 32'({ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk}), 32'(lamp_of(m_phase)));
        chk("ped_ack", 32'(ped_ack), 32'(m_phase == 5 && m_el == 0));
        ph_cnt[phase]++;
        if (ped_ack) ack_seen++;
    endtask

    // Called on a falling edge; drives inputs for one cycle, then compares after the edge.
    task automatic cyc(input bit ns, input bit ew, input bit ped);
        ns_req = ns; ew_req = ew; ped_req = ped;
        @(posedge clk);
        model_step(ns, ew, ped);
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic do_reset();
        #1 reset_n = 1'b1;
        #1;
        chk("rst_async_lamps", 32'({ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk, ped_ack}), 32'h24);
        chk("rst_async_phase", 32'(phase), 32'd4);
        model_reset();
        for (int i = 0; i < 8; i++) ph_cnt[i] = 0;
        ack_seen = 0;
        @(negedge clk);
        ns_req = 0; ew_req = 0; ped_req = 0;
        reset_n = 1'b0;
        compare_outputs();
        ph_cnt[4] = 0;
    endtask

    initial begin
        bit ns_r_l, ew_r_l, reached;
        @(negedge clk);
        do_reset();

        // Idle: all-red for two cycles then NS green rests with no ped_ack.
        cyc(0, 0, 0);
        chk("idle_ar_hold", 32'(phase), 32'd4);
        for (int i = 0; i < 20; i++) cyc(0, 0, 0);
        chk("idle_rest_ns", 32'(phase), 32'd0);
        chk("idle_no_ack", 32'(ack_seen), 32'd0);

        // EW demand only: NS green for MIN, then EW green rests.
        do_reset();
        for (int i = 0; i < 40; i++) cyc(0, 1, 0);
        chk("gap_ns_green_len", 32'(ph_cnt[0]), 32'd4);
        chk("gap_ns_yel_len", 32'(ph_cnt[1]), 32'd2);
        chk("gap_ew_rest", 32'(phase), 32'd2);

        // Both demands: NS green capped at MAX.
        do_reset();
        for (int i = 0; i < 9; i++) cyc(1, 1, 0);
        chk("max_last_green", 32'(phase), 32'd0);
        cyc(1, 1, 0);
        chk("max_then_yel", 32'(phase), 32'd1);

        // Own demand drops in green cycle 6: yellow follows that edge.
        do_reset();
        for (int i = 0; i < 7; i++) cyc(1, 1, 0);
        chk("drop_still_green", 32'(phase), 32'd0);
        cyc(0, 1, 0);
        chk("drop_yel", 32'(phase), 32'd1);

        // Single ped pulse during NS green.
        do_reset();
        cyc(0, 0, 0); cyc(0, 0, 0);
        cyc(0, 0, 1);
        for (int i = 0; i < 12; i++) cyc(0, 0, 0);
        chk("ped_walk_len", 32'(ph_cnt[5]), 32'd3);
        chk("ped_ack_once", 32'(ack_seen), 32'd1);
        chk("ped_then_ew", 32'(phase), 32'd2);

        // Ped held: ignored during walk, re-served only after a vehicle green.
        do_reset();
        for (int i = 0; i < 20; i++) cyc(0, 0, 1);
        chk("pedhold_acks", 32'(ack_seen), 32'd2);
        chk("pedhold_walk_cycles", 32'(ph_cnt[5]), 32'd6);
        chk("pedhold_end_ew", 32'(phase), 32'd2);

        // Asynchronous reset in EW yellow.
        do_reset();
        reached = 0;
        for (int i = 0; i < 60 && !reached; i++) begin
            cyc(1, 1, 0);
            if (phase == 3'd3) reached = 1;
        end
        chk("reach_ew_yel", 32'(reached), 32'd1);
        do_reset();
        cyc(0, 0, 0);
        chk("post_rst_ar", 32'(phase), 32'd4);
        cyc(0, 0, 0);
        chk("post_rst_ns", 32'(phase), 32'd0);

        // Random demand with occasional resets.
        ns_r_l = 0; ew_r_l = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) ns_r_l = ~ns_r_l;
            if ($urandom_range(0, 7) == 0) ew_r_l = ~ew_r_l;
            if ($urandom_range(0, 599) == 0) do_reset();
            else cyc(ns_r_l, ew_r_l, $urandom_range(0, 19) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
